// File: rtl/shiftright_seq_if.sv
// ---------------------------------------------------------------------------
// shiftright_seq_if
//   Request/response bundle for the multi-cycle right shifter.
//   master : requester (drives start/data_in/shamt/arith, observes results)
//   slave  : shifter   (observes the request, drives busy/done/shift_out)
// Signals
//   start      request, sampled by the shifter only while idle
//   data_in    operand, captured on an accepted start
//   shamt      shift amount 0..WIDTH-1, captured on an accepted start
//   arith      1 = sign fill, 0 = zero fill, captured on an accepted start
//   busy       high while shifting
//   done       one-cycle pulse, shift_out valid
//   shift_out  result, held from done until the next accepted start
// ---------------------------------------------------------------------------
interface shiftright_seq_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SHW   = 4
);
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic [SHW-1:0]   shamt;
    logic             arith;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] shift_out;

    modport master (
        output start, data_in, shamt, arith,
        input  busy, done, shift_out
    );

    modport slave (
        input  start, data_in, shamt, arith,
        output busy, done, shift_out
    );
endinterface

// File: rtl/shiftright_seq.sv
// ---------------------------------------------------------------------------
// shiftright_seq
//   Multi-cycle logical/arithmetic right shifter, one bit position per clock.
//   Sequence: IDLE --start--> SHIFT (shamt+1 cycles) --> DONE (1 cycle) --> IDLE
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    shiftright_seq_if.slave: start/data_in/shamt/arith in,
//          busy/done/shift_out out
// ---------------------------------------------------------------------------
module shiftright_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SHW   = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    shiftright_seq_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [WIDTH-1:0] res_q,   res_d;
    logic [SHW-1:0]   cnt_q,   cnt_d;
    logic             mode_q,  mode_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    data_d  = bus.data_in;
                    cnt_d   = bus.shamt;
                    mode_d  = bus.arith;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt_q != '0) begin
                    // Sign fill re-uses the current MSB, which never changes
                    // during an arithmetic shift.
                    data_d = {mode_q & data_q[WIDTH-1], data_q[WIDTH-1:1]};
                    cnt_d  = cnt_q - SHW'(1);
                end else begin
                    res_d   = data_q;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.busy      = (state_q == ST_SHIFT);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.shift_out = res_q;

endmodule

// File: tb/tb_shiftright_seq.sv
module tb_shiftright_seq;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned SHW   = 4;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    shiftright_seq_if #(.WIDTH(WIDTH), .SHW(SHW)) bus ();

    shiftright_seq #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic [3:0]  s;
        logic        a;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[8];

    // Reference: plain shift, with the vacated top bits forced to the sign
    // bit for arithmetic mode.
    function automatic logic [15:0] ref_shift(logic [15:0] x, int s, logic a);
        logic [15:0] ones;
        logic [15:0] r;
        ones = '1;
        r = x >> s;
        if (a && x[15]) r = r | ~(ones >> s);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One operation. With junk=1, start stays high and the operand inputs are
    // scrambled while busy; the original request must still be delivered.
    task automatic do_op(input logic [15:0] d, input logic [3:0] s, input logic a,
                         input bit junk, output logic [15:0] res,
                         output int lat, output int busy_n, output int done_n);
        @(negedge clk);
        bus.start = 1'b1; bus.data_in = d; bus.shamt = s; bus.arith = a;
        @(posedge clk); #1;
        if (junk) begin
            bus.data_in = 16'($urandom); bus.shamt = 4'($urandom); bus.arith = ~a;
        end else begin
            bus.start = 1'b0;
        end
        lat = -1; busy_n = 0; done_n = 0; res = '0;
        if (bus.busy) busy_n++;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                lat = k; done_n++;
                res = bus.shift_out;
                bus.start = 1'b0;
                break;
            end
            if (bus.busy) busy_n++;
            if (junk) bus.data_in = 16'($urandom);
        end
        if (lat < 0) begin
            n_tests++; n_fail++;
            $display("FAIL op_timeout: no done within 40 cycles, expected done");
            bus.start = 1'b0;
        end else begin
            check("busy_at_done", {31'd0, bus.busy}, 32'd0);
            @(posedge clk); #1;
            if (bus.done) done_n++;
            check("result_held", {16'd0, bus.shift_out}, {16'd0, res});
        end
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (!bus.busy && !bus.done) begin ok = 1'b1; break; end
        end
        check("drain_idle", {31'd0, ok}, 32'd1);
    endtask

    initial begin
        logic [15:0] res, d, exp;
        logic [3:0]  s;
        logic        a;
        int          lat, busy_n, done_n, dcount;
        int          first_done, second_done;
        logic [15:0] r1, r2;

        n_tests = 0; n_fail = 0;

        vecs[0] = '{16'h00A0, 4'd3,  1'b0, 16'h0014};
        vecs[1] = '{16'h8000, 4'd4,  1'b1, 16'hF800};
        vecs[2] = '{16'h8000, 4'd4,  1'b0, 16'h0800};
        vecs[3] = '{16'h1234, 4'd0,  1'b0, 16'h1234};
        vecs[4] = '{16'h8000, 4'd15, 1'b0, 16'h0001};
        vecs[5] = '{16'h8000, 4'd15, 1'b1, 16'hFFFF};
        vecs[6] = '{16'h7FFF, 4'd15, 1'b1, 16'h0000};
        vecs[7] = '{16'hF0F0, 4'd8,  1'b1, 16'hFFF0};

        // Reset held for two cycles.
        rst_n = 1'b0;
        bus.start = 1'b0; bus.data_in = '0; bus.shamt = '0; bus.arith = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("reset_busy",      {31'd0, bus.busy}, 32'd0);
        check("reset_done",      {31'd0, bus.done}, 32'd0);
        check("reset_shift_out", {16'd0, bus.shift_out}, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Directed vectors.
        foreach (vecs[i]) begin
            do_op(vecs[i].d, vecs[i].s, vecs[i].a, 1'b0, res, lat, busy_n, done_n);
            check($sformatf("vec%0d_result", i), {16'd0, res}, {16'd0, vecs[i].exp});
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].s) + 32'd1);
            check($sformatf("vec%0d_busy_cycles", i), 32'(busy_n), 32'(vecs[i].s) + 32'd1);
            check($sformatf("vec%0d_done_pulses", i), 32'(done_n), 32'd1);
        end

        // Start asserted while busy, with changing operands: ignored.
        do_op(16'hC3A5, 4'd6, 1'b1, 1'b1, res, lat, busy_n, done_n);
        check("busy_start_result",  {16'd0, res}, {16'd0, ref_shift(16'hC3A5, 6, 1'b1)});
        check("busy_start_latency", 32'(lat), 32'd7);
        check("busy_start_pulses",  32'(done_n), 32'd1);

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            d = 16'($urandom); s = 4'($urandom); a = 1'($urandom);
            exp = ref_shift(d, int'(s), a);
            do_op(d, s, a, ($urandom_range(0, 3) == 0), res, lat, busy_n, done_n);
            check($sformatf("rand%0d_result", i), {16'd0, res}, {16'd0, exp});
            check($sformatf("rand%0d_latency", i), 32'(lat), 32'(s) + 32'd1);
        end

        // Start held high: back-to-back operations, one per shamt+3 cycles.
        @(negedge clk);
        bus.start = 1'b1; bus.data_in = 16'h00F0; bus.shamt = 4'd2; bus.arith = 1'b0;
        first_done = -1; second_done = -1; r1 = '0; r2 = '0;
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                if (first_done < 0) begin first_done = k; r1 = bus.shift_out; end
                else if (second_done < 0) begin second_done = k; r2 = bus.shift_out; end
            end
        end
        bus.start = 1'b0;
        check("b2b_first_done",  32'(first_done), 32'd4);
        check("b2b_gap",         32'(second_done - first_done), 32'd5);
        check("b2b_result1",     {16'd0, r1}, 32'h003C);
        check("b2b_result2",     {16'd0, r2}, 32'h003C);
        drain();

        // Reset during SHIFT of a shamt=10 op.
        do_op(16'hABCD, 4'd0, 1'b0, 1'b0, res, lat, busy_n, done_n);
        check("pre_reset_result", {16'd0, res}, 32'h0000ABCD);
        @(negedge clk);
        bus.start = 1'b1; bus.data_in = 16'hFFFF; bus.shamt = 4'd10; bus.arith = 1'b1;
        @(posedge clk); #1; bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy",      {31'd0, bus.busy}, 32'd0);
        check("midrst_shift_out", {16'd0, bus.shift_out}, 32'd0);
        dcount = 0;
        repeat (2) begin @(posedge clk); #1; if (bus.done) dcount++; end
        @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (bus.done) dcount++;
        end
        check("midrst_no_done",   32'(dcount), 32'd0);
        check("midrst_out_held",  {16'd0, bus.shift_out}, 32'd0);
        do_op(16'h9000, 4'd3, 1'b1, 1'b0, res, lat, busy_n, done_n);
        check("post_reset_result",  {16'd0, res}, 32'h0000F200);
        check("post_reset_latency", 32'(lat), 32'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
